// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM state encoding and wait-counter width.
package apb_pkg;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_ACCESS = 2'd1,
      APB_DONE   = 2'd2
   } apb_state_t;

   localparam int unsigned APB_CNT_W = 4;

endpackage

// File: rtl/apb_regfile_slave_bank.sv
// Register storage for apb_regfile_slave: byte-strobed writes, read-only mask,
// indexed read mux and flattened register view.
module apb_reg_bank #(
   parameter int unsigned DATA_W             = 32,
   parameter int unsigned NUM_REGS           = 16,
   parameter int unsigned IDX_W              = 6,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
   parameter logic [DATA_W-1:0]   RESET_VAL  = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [IDX_W-1:0]             widx,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic [IDX_W-1:0]             ridx,
   output logic [DATA_W-1:0]            rdata,
   output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            mem[i] <= RESET_VAL;
         end
      end else if (we) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (widx == IDX_W'(i) && !RO_MASK[i]) begin
               for (int unsigned b = 0; b < DATA_W/8; b++) begin
                  if (wstrb[b]) begin
                     mem[i][b*8 +: 8] <= wdata[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // Out-of-range indices fall through to zero.
   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (ridx == IDX_W'(i)) begin
            rdata = mem[i];
         end
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         regs_flat[i*DATA_W +: DATA_W] = mem[i];
      end
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 completer fronting a parametrised register bank, with wait states,
// read-only masking and PSLVERR on out-of-range or read-only writes.
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W             = 8,
   parameter int unsigned DATA_W             = 32,
   parameter int unsigned NUM_REGS           = 16,
   parameter int unsigned WAIT_CYCLES        = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
   parameter logic [DATA_W-1:0]   RESET_VAL  = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W/8-1:0]          pstrb,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

   localparam int unsigned IDX_W = ADDR_W - 2;

   apb_state_t             state, state_n;
   logic [APB_CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]       idx_q;
   logic                   pwrite_q;
   logic [DATA_W-1:0]      pwdata_q;
   logic [DATA_W/8-1:0]    pstrb_q;
   logic                   err_q;

   logic                   load;
   logic                   commit;
   logic [IDX_W-1:0]       idx_in;
   logic                   ro_bit;
   logic                   err_in;
   logic [DATA_W-1:0]      rdata;
   logic                   unused_addr_lsb;

   assign idx_in          = paddr[ADDR_W-1:2];
   assign unused_addr_lsb = ^paddr[1:0];

   always_comb begin
      ro_bit = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (idx_in == IDX_W'(i)) begin
            ro_bit = RO_MASK[i];
         end
      end
   end

   // Error is decided at setup so the response depends only on captured state.
   assign err_in = ({1'b0, idx_in} >= (IDX_W+1)'(NUM_REGS)) || (pwrite && ro_bit);

   always_comb begin
      state_n = state;
      load    = 1'b0;
      commit  = 1'b0;
      case (state)
         APB_IDLE, APB_DONE: begin
            if (psel && !penable) begin
               state_n = APB_ACCESS;
               load    = 1'b1;
            end else begin
               state_n = APB_IDLE;
            end
         end
         APB_ACCESS: begin
            if (!psel) begin
               state_n = APB_IDLE;
            end else if (penable && cnt == '0) begin
               state_n = APB_DONE;
               commit  = pwrite_q && !err_q;
            end
         end
         default: state_n = APB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= APB_IDLE;
         cnt      <= '0;
         idx_q    <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            cnt      <= APB_CNT_W'(WAIT_CYCLES);
            idx_q    <= idx_in;
            pwrite_q <= pwrite;
            pwdata_q <= pwdata;
            pstrb_q  <= pstrb;
            err_q    <= err_in;
         end else if (state == APB_ACCESS && cnt != '0) begin
            cnt <= cnt - APB_CNT_W'(1);
         end
      end
   end

   apb_reg_bank #(
      .DATA_W    (DATA_W),
      .NUM_REGS  (NUM_REGS),
      .IDX_W     (IDX_W),
      .RO_MASK   (RO_MASK),
      .RESET_VAL (RESET_VAL)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .we        (commit),
      .widx      (idx_q),
      .wdata     (pwdata_q),
      .wstrb     (pstrb_q),
      .ridx      (idx_q),
      .rdata     (rdata),
      .regs_flat (regs_flat)
   );

   // Responses decode flopped state only; no APB input reaches an output.
   assign pready  = (state == APB_ACCESS) && (cnt == '0);
   assign pslverr = pready && err_q;
   assign prdata  = (pready && !pwrite_q && !err_q) ? rdata : '0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: one instance with no wait states and a
// read-only register, one with three wait states, sharing the APB bus.
module tb_apb_regfile_slave;

   localparam logic [31:0] RV = 32'h0000_1234;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          psel0 = 1'b0, psel3 = 1'b0;
   logic          penable = 1'b0, pwrite = 1'b0;
   logic [7:0]    paddr = '0;
   logic [31:0]   pwdata = '0;
   logic [3:0]    pstrb = '0;
   logic [31:0]   prdata0, prdata3;
   logic          pready0, pready3, pslverr0, pslverr3;
   logic [511:0]  flat0, flat3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   apb_regfile_slave #(
      .ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(0),
      .RO_MASK(16'h0010), .RESET_VAL(RV)
   ) dut0 (
      .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
      .pready(pready0), .pslverr(pslverr0), .regs_flat(flat0)
   );

   apb_regfile_slave #(
      .ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(3),
      .RO_MASK(16'h0000), .RESET_VAL(RV)
   ) dut3 (
      .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3),
      .pready(pready3), .pslverr(pslverr3), .regs_flat(flat3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg0(input int i);
      return flat0[i*32 +: 32];
   endfunction

   function automatic logic [31:0] reg3(input int i);
      return flat3[i*32 +: 32];
   endfunction

   function automatic logic cur_ready(input bit d);
      return d ? pready3 : pready0;
   endfunction

   // Full transfer; returns after the completion edge (+1) so a follow-on call is back-to-back.
   task automatic xfer(input bit d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] sb, output logic [31:0] rd, output logic er,
                       output int lat);
      psel0 = !d; psel3 = d; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = wd; pstrb = sb;
      @(posedge clk); #1;
      penable = 1'b1;
      lat = 0;
      while (!cur_ready(d) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("pready_seen", {31'b0, cur_ready(d)}, 32'd1);
      rd = d ? prdata3 : prdata0;
      er = d ? pslverr3 : pslverr0;
      @(posedge clk); #1;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          seen;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_pready0", {31'b0, pready0}, 32'd0);
      chk("rst_pslverr0", {31'b0, pslverr0}, 32'd0);
      chk("rst_prdata0", prdata0, 32'd0);
      chk("rst_pready3", {31'b0, pready3}, 32'd0);
      chk("rst_reg0_0", reg0(0), RV);
      chk("rst_reg0_15", reg0(15), RV);
      chk("rst_reg3_7", reg3(7), RV);

      // Basic write/read, no wait states
      xfer(0, 1, 8'h08, 32'hDEADBEEF, 4'hF, rd, er, lat);
      chk("wr_lat", lat, 0);
      chk("wr_err", {31'b0, er}, 32'd0);
      chk("wr_prdata", rd, 32'd0);
      chk("wr_reg2", reg0(2), 32'hDEADBEEF);
      chk("done_pready", {31'b0, pready0}, 32'd0);
      xfer(0, 0, 8'h08, 32'h0, 4'h0, rd, er, lat);
      chk("rd_lat", lat, 0);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_err", {31'b0, er}, 32'd0);

      // Byte strobes, then back-to-back read of the same address
      xfer(0, 1, 8'h0B, 32'h11223344, 4'b0101, rd, er, lat);
      chk("strb_reg2", reg0(2), 32'hDE22BE44);
      xfer(0, 0, 8'h08, 32'h0, 4'h0, rd, er, lat);
      chk("b2b_rd", rd, 32'hDE22BE44);

      // Errors
      xfer(0, 1, 8'h40, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      chk("oor_wr_err", {31'b0, er}, 32'd1);
      chk("oor_wr_reg0", reg0(0), RV);
      chk("oor_wr_reg2", reg0(2), 32'hDE22BE44);
      xfer(0, 1, 8'h10, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      chk("ro_wr_err", {31'b0, er}, 32'd1);
      chk("ro_wr_reg4", reg0(4), RV);
      xfer(0, 0, 8'h40, 32'h0, 4'h0, rd, er, lat);
      chk("oor_rd_err", {31'b0, er}, 32'd1);
      chk("oor_rd_data", rd, 32'd0);
      xfer(0, 0, 8'h10, 32'h0, 4'h0, rd, er, lat);
      chk("ro_rd_err", {31'b0, er}, 32'd0);
      chk("ro_rd_data", rd, RV);

      // Access phase without a preceding setup is ignored
      psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h08;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         seen += int'(pready0);
      end
      chk("nosetup_pready", seen, 0);
      psel0 = 1'b0; penable = 1'b0;
      @(posedge clk); #1;

      // Reset during the access phase of a write
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14;
      pwdata = 32'h55AA55AA; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      chk("midrst_pre_ready", {31'b0, pready0}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; psel0 = 1'b0; penable = 1'b0;
      chk("midrst_pready", {31'b0, pready0}, 32'd0);
      chk("midrst_pslverr", {31'b0, pslverr0}, 32'd0);
      chk("midrst_prdata", prdata0, 32'd0);
      chk("midrst_reg5", reg0(5), RV);
      chk("midrst_reg2", reg0(2), RV);
      @(posedge clk); #1;
      chk("midrst_reg5_later", reg0(5), RV);

      // Wait states
      xfer(1, 0, 8'h08, 32'h0, 4'h0, rd, er, lat);
      chk("ws_rd_lat", lat, 3);
      chk("ws_rd_data", rd, RV);
      xfer(1, 1, 8'h0C, 32'hCAFEF00D, 4'hF, rd, er, lat);
      chk("ws_wr_lat", lat, 3);
      chk("ws_wr_reg3", reg3(3), 32'hCAFEF00D);
      xfer(1, 0, 8'h0C, 32'h0, 4'h0, rd, er, lat);
      chk("ws_b2b_rd", rd, 32'hCAFEF00D);
      chk("ws_b2b_lat", lat, 3);

      // Abort mid-wait
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18;
      pwdata = 32'h0BADF00D; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      seen = int'(pready3);
      @(posedge clk); #1;
      seen += int'(pready3);
      psel3 = 1'b0; penable = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         seen += int'(pready3);
      end
      chk("abort_pready", seen, 0);
      chk("abort_reg6", reg3(6), RV);
      xfer(1, 0, 8'h18, 32'h0, 4'h0, rd, er, lat);
      chk("abort_rd_lat", lat, 3);
      chk("abort_rd_data", rd, RV);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
